// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   AW_DEF / DW_DEF : default address and data widths
//   state_t         : arbiter sequencing states
package mem_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port memory.
//   reqN_*  : request handshake and fields from port N (N = 0, 1)
//   rspN_*  : one-cycle completion pulse and read data to port N
//   mem_*   : memory control (we/addr/din out, dout in)
// slave  : arbiter side
// master : requester / memory side
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_dout,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output mem_we, mem_addr, mem_din
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_dout,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker.
//   valid_i : request present per port
//   last_i  : most recently granted port
//   grant_o : one-hot grant (all zero when nothing is valid)
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);
    // A lone requester always wins; on contention the port that was not
    // granted last time goes first.
    assign grant_o[0] = valid_i[0] & (~valid_i[1] | last_i);
    assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);
endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.slave (requests, responses, memory control)
// One access every three cycles: IDLE (accept) -> ISSUE (write strobe)
// -> RESP (capture read data); the response pulses the cycle after RESP.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    state_t                 state_q, state_d;
    logic                   last_q;
    logic                   port_q;
    logic                   we_q;
    logic [AW-1:0]          addr_q;
    logic [DW-1:0]          wdata_q;
    logic [1:0]             rsp_valid_q;
    logic [1:0][DW-1:0]     rsp_rdata_q;

    logic [1:0] valid;
    logic [1:0] grant;
    logic       accept;

    assign valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_pick (
        .valid_i (valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign accept = (state_q == IDLE) && (|valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|valid) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            if (accept) begin
                port_q  <= grant[1];
                last_q  <= grant[1];
                we_q    <= grant[1] ? bus.req1_we    : bus.req0_we;
                addr_q  <= grant[1] ? bus.req1_addr  : bus.req0_addr;
                wdata_q <= grant[1] ? bus.req1_wdata : bus.req0_wdata;
            end
            if (state_q == RESP) begin
                rsp_valid_q[port_q] <= 1'b1;
                rsp_rdata_q[port_q] <= we_q ? '0 : bus.mem_dout;
            end
        end
    end

    // Ready only while idle, so grants never overlap an access in flight.
    assign bus.req0_ready = grant[0] & (state_q == IDLE);
    assign bus.req1_ready = grant[1] & (state_q == IDLE);

    // Address/data come straight from the latched request so they stay
    // stable through RESP; the write strobe is confined to ISSUE.
    assign bus.mem_we   = we_q & (state_q == ISSUE);
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = wdata_q;

    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_rdata = rsp_rdata_q[0];
    assign bus.rsp1_rdata = rsp_rdata_q[1];
endmodule
